// File: rtl/gen_reduce_if.sv
// Generator-protocol bundle seen by gen_reduce: its own caller side plus its child side.
// Latency: none, wires only.
// Backpressure: carries the ready/valid/done handshakes; no storage of its own.
interface gen_reduce_if #(
    parameter int WIDTH = 32
);
    // caller -> reducer
    logic                    _start;
    logic signed [WIDTH-1:0] base;
    logic signed [WIDTH-1:0] limit;
    logic signed [WIDTH-1:0] step;
    logic                    _ready;
    // reducer -> caller
    logic                    _valid;
    logic                    _done;
    logic signed [WIDTH-1:0] _0;
    logic signed [WIDTH-1:0] _1;
    logic signed [WIDTH-1:0] _2;
    logic signed [WIDTH-1:0] _3;
    // reducer -> child
    logic                    child__start;
    logic                    child__ready;
    logic signed [WIDTH-1:0] child_base;
    logic signed [WIDTH-1:0] child_limit;
    logic signed [WIDTH-1:0] child_step;
    // child -> reducer
    logic                    child__valid;
    logic                    child__done;
    logic signed [WIDTH-1:0] child__0;

    // The reducer itself.
    modport master (
        input  _start, base, limit, step, _ready,
        input  child__valid, child__done, child__0,
        output _valid, _done, _0, _1, _2, _3,
        output child__start, child__ready, child_base, child_limit, child_step
    );

    // The environment: the caller above and the child generator below.
    modport slave (
        output _start, base, limit, step, _ready,
        output child__valid, child__done, child__0,
        input  _valid, _done, _0, _1, _2, _3,
        input  child__start, child__ready, child_base, child_limit, child_step
    );
endinterface

// File: rtl/gen_reduce.sv
// Launches a child generator, drains its items and reduces them to (sum, count, min, max).
// Latency: tuple valid 1 cycle after the child's honoured done; done 1 cycle after the tuple handshake.
// Backpressure: child throttled by child__ready (optional idle gap per item); tuple held until _ready.
module gen_reduce #(
    parameter int WIDTH     = 32,
    parameter int READY_GAP = 0
) (
    input  logic         _clock,
    input  logic         _reset,
    gen_reduce_if.master bus
);

    localparam int GW = (READY_GAP > 1) ? $clog2(READY_GAP + 1) : 1;

    // Accumulator seeds: min starts at the largest positive value, max at its negation.
    localparam logic signed [WIDTH-1:0] L_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] L_NEG_MAX = -L_POS_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_CONSUME,
        S_GAP,
        S_EMIT
    } state_t;

    state_t                  r_state;

    // Running reduction of the current child stream.
    logic signed [WIDTH-1:0] r_sum;
    logic signed [WIDTH-1:0] r_cnt;
    logic signed [WIDTH-1:0] r_min;
    logic signed [WIDTH-1:0] r_max;

    // Registered outputs.
    logic                    r_valid;
    logic                    r_done;
    logic signed [WIDTH-1:0] r_0;
    logic signed [WIDTH-1:0] r_1;
    logic signed [WIDTH-1:0] r_2;
    logic signed [WIDTH-1:0] r_3;
    logic                    r_child_start;
    logic                    r_child_ready;
    logic signed [WIDTH-1:0] r_child_base;
    logic signed [WIDTH-1:0] r_child_limit;
    logic signed [WIDTH-1:0] r_child_step;

    // r_mask: first CONSUME cycle, where the child's done may still be from its last run.
    // r_done_pend: done arrived together with an item; honour it once that item is taken.
    logic                    r_mask;
    logic                    r_done_pend;
    logic [GW-1:0]           r_gap_cnt;

    logic                    w_accept;
    logic                    w_done_hit;

    // Item handshake with the child, and a done that may end the stream this cycle.
    always_comb begin
        w_accept   = 1'b0;
        w_done_hit = 1'b0;
        if (r_state == S_CONSUME) begin
            w_accept   = r_child_ready && bus.child__valid;
            w_done_hit = !r_mask && (bus.child__done || r_done_pend);
        end
    end

    // Control FSM, reduction and all registered outputs; a new _start overrides any state.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            r_state       <= S_IDLE;
            r_sum         <= '0;
            r_cnt         <= '0;
            r_min         <= '0;
            r_max         <= '0;
            r_valid       <= 1'b0;
            r_done        <= 1'b0;
            r_0           <= '0;
            r_1           <= '0;
            r_2           <= '0;
            r_3           <= '0;
            r_child_start <= 1'b0;
            r_child_ready <= 1'b0;
            r_child_base  <= '0;
            r_child_limit <= '0;
            r_child_step  <= '0;
            r_mask        <= 1'b0;
            r_done_pend   <= 1'b0;
            r_gap_cnt     <= '0;
        end else if (bus._start) begin
            r_child_base  <= bus.base;
            r_child_limit <= bus.limit;
            r_child_step  <= bus.step;
            r_sum         <= '0;
            r_cnt         <= '0;
            r_min         <= L_POS_MAX;
            r_max         <= L_NEG_MAX;
            r_valid       <= 1'b0;
            r_done        <= 1'b0;
            r_child_start <= 1'b1;
            r_child_ready <= 1'b0;
            r_mask        <= 1'b0;
            r_done_pend   <= 1'b0;
            r_state       <= S_LAUNCH;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done        <= 1'b1;
                    r_valid       <= 1'b0;
                    r_child_start <= 1'b0;
                    r_child_ready <= 1'b0;
                end

                S_LAUNCH: begin
                    r_child_start <= 1'b0;
                    r_child_ready <= 1'b1;
                    r_mask        <= 1'b1;
                    r_done_pend   <= 1'b0;
                    r_state       <= S_CONSUME;
                end

                S_CONSUME: begin
                    r_mask <= 1'b0;
                    if (w_accept) begin
                        r_sum <= r_sum + bus.child__0;
                        r_cnt <= r_cnt + WIDTH'(1);
                        if (bus.child__0 < r_min) r_min <= bus.child__0;
                        if (bus.child__0 > r_max) r_max <= bus.child__0;
                        if (!r_mask && bus.child__done) r_done_pend <= 1'b1;
                        if (READY_GAP > 0) begin
                            r_child_ready <= 1'b0;
                            r_gap_cnt     <= GW'(READY_GAP);
                            r_state       <= S_GAP;
                        end
                    end else if (w_done_hit) begin
                        // Stream finished: latch the tuple; an empty run reports min = max = 0.
                        r_child_ready <= 1'b0;
                        r_done_pend   <= 1'b0;
                        r_valid       <= 1'b1;
                        r_0           <= r_sum;
                        r_1           <= r_cnt;
                        r_2           <= (r_cnt == '0) ? '0 : r_min;
                        r_3           <= (r_cnt == '0) ? '0 : r_max;
                        r_state       <= S_EMIT;
                    end
                end

                S_GAP: begin
                    r_child_ready <= 1'b0;
                    if (r_gap_cnt <= GW'(1)) begin
                        r_child_ready <= 1'b1;
                        r_state       <= S_CONSUME;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                    end
                end

                S_EMIT: begin
                    if (bus._ready) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus._valid       = r_valid;
    assign bus._done        = r_done;
    assign bus._0           = r_0;
    assign bus._1           = r_1;
    assign bus._2           = r_2;
    assign bus._3           = r_3;
    assign bus.child__start = r_child_start;
    assign bus.child__ready = r_child_ready;
    assign bus.child_base   = r_child_base;
    assign bus.child_limit  = r_child_limit;
    assign bus.child_step   = r_child_step;

endmodule

// File: tb/tb_gen_reduce.sv
// Bench for gen_reduce: two instances (full rate and READY_GAP=2) driven by a range-style child.
// Latency: checks the exact cycles of _valid, _done and child__ready against hand-derived timing.
// Backpressure: exercises caller _ready hold-off and the per-item child ready gap.
module tb_gen_reduce;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gen_reduce_if #(.WIDTH(W)) bus0 ();
    gen_reduce_if #(.WIDTH(W)) bus1 ();

    gen_reduce #(.WIDTH(W), .READY_GAP(0)) u_dut0 (._clock(clk), ._reset(rst_n), .bus(bus0));
    gen_reduce #(.WIDTH(W), .READY_GAP(2)) u_dut1 (._clock(clk), ._reset(rst_n), .bus(bus1));

    // Stimulus (sel picks which instance receives _start and is observed).
    logic                sel      = 1'b0;
    logic                tb_start = 1'b0;
    logic signed [W-1:0] tb_base  = '0;
    logic signed [W-1:0] tb_limit = '0;
    logic signed [W-1:0] tb_step  = '0;
    logic                tb_ready = 1'b0;
    logic                ch_valid = 1'b0;
    logic                ch_done  = 1'b0;
    logic signed [W-1:0] ch_item  = '0;

    assign bus0._start       = tb_start & ~sel;
    assign bus1._start       = tb_start & sel;
    assign bus0.base         = tb_base;
    assign bus1.base         = tb_base;
    assign bus0.limit        = tb_limit;
    assign bus1.limit        = tb_limit;
    assign bus0.step         = tb_step;
    assign bus1.step         = tb_step;
    assign bus0._ready       = tb_ready;
    assign bus1._ready       = tb_ready;
    assign bus0.child__valid = ch_valid;
    assign bus1.child__valid = ch_valid;
    assign bus0.child__done  = ch_done;
    assign bus1.child__done  = ch_done;
    assign bus0.child__0     = ch_item;
    assign bus1.child__0     = ch_item;

    logic                o_valid, o_done, c_start, c_ready;
    logic signed [W-1:0] o_0, o_1, o_2, o_3, c_base, c_limit, c_step;

    assign o_valid = sel ? bus1._valid       : bus0._valid;
    assign o_done  = sel ? bus1._done        : bus0._done;
    assign c_start = sel ? bus1.child__start : bus0.child__start;
    assign c_ready = sel ? bus1.child__ready : bus0.child__ready;
    assign o_0     = sel ? bus1._0           : bus0._0;
    assign o_1     = sel ? bus1._1           : bus0._1;
    assign o_2     = sel ? bus1._2           : bus0._2;
    assign o_3     = sel ? bus1._3           : bus0._3;
    assign c_base  = sel ? bus1.child_base   : bus0.child_base;
    assign c_limit = sel ? bus1.child_limit  : bus0.child_limit;
    assign c_step  = sel ? bus1.child_step   : bus0.child_step;

    int n_checks = 0;
    int n_pass   = 0;

    // Range child: items base, base+step, ... while < limit, then done held high.
    // slow_child keeps its previous outputs for one extra cycle after start.
    bit slow_child = 1'b0;

    initial begin : child_model
        int cur, lim, stp;
        bit active, pend, s_start, s_acc;
        int s_base, s_lim, s_stp;
        active = 1'b0;
        pend   = 1'b0;
        cur = 0; lim = 0; stp = 0;
        forever begin
            @(negedge clk);
            s_start = c_start;
            s_acc   = c_ready && ch_valid;
            s_base  = c_base;
            s_lim   = c_limit;
            s_stp   = c_step;
            @(posedge clk);
            #1;
            if (pend) begin
                pend   = 1'b0;
                active = 1'b1;
            end else if (s_start) begin
                cur = s_base; lim = s_lim; stp = s_stp;
                if (slow_child) pend = 1'b1;
                else            active = 1'b1;
            end else if (s_acc && active) begin
                cur = cur + stp;
            end
            if (active) begin
                if (cur < lim) begin
                    ch_valid = 1'b1;
                    ch_item  = cur;
                    ch_done  = 1'b0;
                end else begin
                    ch_valid = 1'b0;
                    ch_done  = 1'b1;
                    active   = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int b, input int l, input int s);
        tick();
        tb_base  = b;
        tb_limit = l;
        tb_step  = s;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
    endtask

    task automatic wait_valid(input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) begin
            n_checks++;
            $display("FAIL %s_timeout: _valid=%0b after 300 cycles, required 1", name, o_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({o_valid, o_done, c_start, c_ready} !== 4'b0000)
            $display("FAIL reset_ctrl: valid/done/cstart/cready=%b required 0000",
                     {o_valid, o_done, c_start, c_ready});
        else n_pass++;
        n_checks++;
        if ({o_0, o_1, o_2, o_3, c_base, c_limit, c_step} !== '0)
            $display("FAIL reset_data: tuple (%0d,%0d,%0d,%0d) args (%0d,%0d,%0d) required all 0",
                     o_0, o_1, o_2, o_3, c_base, c_limit, c_step);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({o_done, o_valid} !== 2'b10)
            $display("FAIL reset_release: done/valid=%b required 10", {o_done, o_valid});
        else n_pass++;
    endtask

    task automatic test_basic();
        bit got;
        sel = 1'b0;
        tb_ready = 1'b1;
        pulse_start(0, 10, 2);
        n_checks++;
        if ({c_start, c_ready, c_base, c_limit, c_step} !== {1'b1, 1'b0, 32'sd0, 32'sd10, 32'sd2})
            $display("FAIL basic_launch: start=%0b ready=%0b args (%0d,%0d,%0d) required 1 0 (0,10,2)",
                     c_start, c_ready, c_base, c_limit, c_step);
        else n_pass++;
        wait_valid("basic", got);
        if (got) begin
            n_checks++;
            if ({o_0, o_1, o_2, o_3} !== {32'sd20, 32'sd5, 32'sd0, 32'sd8})
                $display("FAIL basic_tuple: got (%0d,%0d,%0d,%0d) required (20,5,0,8)", o_0, o_1, o_2, o_3);
            else n_pass++;
            tick();
            n_checks++;
            if ({o_valid, o_done} !== 2'b01)
                $display("FAIL basic_after: valid/done=%b required 01", {o_valid, o_done});
            else n_pass++;
        end
    endtask

    task automatic test_negative();
        bit got;
        pulse_start(-3, 4, 3);
        wait_valid("negative", got);
        if (got) begin
            n_checks++;
            if ({o_0, o_1, o_2, o_3} !== {32'sd0, 32'sd3, -32'sd3, 32'sd3})
                $display("FAIL neg_tuple: got (%0d,%0d,%0d,%0d) required (0,3,-3,3)", o_0, o_1, o_2, o_3);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_empty();
        pulse_start(5, 5, 1);
        tick();
        tick();
        n_checks++;
        if (o_valid !== 1'b0)
            $display("FAIL empty_early: valid=%0b in masked+done cycles, required 0", o_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({o_valid, o_0, o_1, o_2, o_3} !== {1'b1, 128'd0})
            $display("FAIL empty_tuple: valid=%0b (%0d,%0d,%0d,%0d) required 1 (0,0,0,0)",
                     o_valid, o_0, o_1, o_2, o_3);
        else n_pass++;
        tick();
    endtask

    task automatic test_stale_done();
        bit got;
        slow_child = 1'b1;
        n_checks++;
        if (ch_done !== 1'b1)
            $display("FAIL stale_setup: child done=%0b before restart, required 1", ch_done);
        else n_pass++;
        pulse_start(0, 4, 1);
        wait_valid("stale", got);
        if (got) begin
            n_checks++;
            if ({o_0, o_1, o_2, o_3} !== {32'sd6, 32'sd4, 32'sd0, 32'sd3})
                $display("FAIL stale_tuple: got (%0d,%0d,%0d,%0d) required (6,4,0,3)", o_0, o_1, o_2, o_3);
            else n_pass++;
            tick();
        end
        slow_child = 1'b0;
    endtask

    task automatic test_hold();
        bit got;
        tb_ready = 1'b0;
        pulse_start(1, 4, 1);
        wait_valid("hold", got);
        if (got) begin
            for (int k = 0; k < 7; k++) begin
                n_checks++;
                if ({o_valid, o_0, o_1, o_2, o_3} !== {1'b1, 32'sd6, 32'sd3, 32'sd1, 32'sd3})
                    $display("FAIL hold_cycle%0d: valid=%0b (%0d,%0d,%0d,%0d) required 1 (6,3,1,3)",
                             k, o_valid, o_0, o_1, o_2, o_3);
                else n_pass++;
                if (k < 6) tick();
            end
            tb_ready = 1'b1;
            tick();
            n_checks++;
            if ({o_valid, o_done} !== 2'b01)
                $display("FAIL hold_release: valid/done=%b required 01", {o_valid, o_done});
            else n_pass++;
        end
        tb_ready = 1'b1;
    endtask

    task automatic test_start_mid_run();
        bit got;
        pulse_start(100, 200, 1);
        repeat (4) tick();
        n_checks++;
        if ({c_ready, o_valid} !== 2'b10)
            $display("FAIL midstart_running: ready/valid=%b required 10", {c_ready, o_valid});
        else n_pass++;
        pulse_start(0, 3, 1);
        wait_valid("midstart", got);
        if (got) begin
            n_checks++;
            if ({o_0, o_1, o_2, o_3} !== {32'sd3, 32'sd3, 32'sd0, 32'sd2})
                $display("FAIL midstart_tuple: got (%0d,%0d,%0d,%0d) required (3,3,0,2)", o_0, o_1, o_2, o_3);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start(0, 100, 1);
        repeat (5) tick();
        n_checks++;
        if (c_ready !== 1'b1)
            $display("FAIL rstmid_consume: child ready=%0b required 1", c_ready);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_done, c_start, c_ready, o_0, o_1, o_2, o_3, c_base, c_limit, c_step} !== '0)
            $display("FAIL rstmid_clear: ctrl=%b tuple (%0d,%0d,%0d,%0d) limit=%0d required all 0",
                     {o_valid, o_done, c_start, c_ready}, o_0, o_1, o_2, o_3, c_limit);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({o_done, o_valid} !== 2'b10)
            $display("FAIL rstmid_release: done/valid=%b required 10", {o_done, o_valid});
        else n_pass++;
    endtask

    task automatic test_gap();
        bit got;
        bit tr_rdy[$];
        bit tr_acc[$];
        int n_acc, bad;
        sel = 1'b1;
        tb_ready = 1'b1;
        pulse_start(0, 10, 2);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_valid) begin
                got = 1'b1;
                break;
            end
            tr_rdy.push_back(c_ready);
            tr_acc.push_back(c_ready && ch_valid);
        end
        if (!got) begin
            n_checks++;
            $display("FAIL gap_timeout: _valid=%0b after 200 cycles, required 1", o_valid);
        end else begin
            n_acc = 0;
            bad   = 0;
            for (int i = 0; i < tr_acc.size(); i++) begin
                if (tr_acc[i]) begin
                    n_acc++;
                    if (i + 3 >= tr_rdy.size()) bad++;
                    else if (tr_rdy[i+1] !== 1'b0 || tr_rdy[i+2] !== 1'b0 || tr_rdy[i+3] !== 1'b1) bad++;
                end
            end
            n_checks++;
            if (n_acc != 5) $display("FAIL gap_accepts: %0d items accepted, required 5", n_acc);
            else n_pass++;
            n_checks++;
            if (bad != 0) $display("FAIL gap_pattern: %0d accepts without a 2-cycle ready gap, required 0", bad);
            else n_pass++;
            n_checks++;
            if ({o_0, o_1, o_2, o_3} !== {32'sd20, 32'sd5, 32'sd0, 32'sd8})
                $display("FAIL gap_tuple: got (%0d,%0d,%0d,%0d) required (20,5,0,8)", o_0, o_1, o_2, o_3);
            else n_pass++;
            tick();
            n_checks++;
            if ({o_valid, o_done} !== 2'b01)
                $display("FAIL gap_after: valid/done=%b required 01", {o_valid, o_done});
            else n_pass++;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_basic();
        test_negative();
        test_empty();
        test_stale_done();
        test_hold();
        test_start_mid_run();
        test_reset_mid_run();
        test_gap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
